// File: rtl/level_display_driver.sv
// Four-digit multiplexed 7-segment driver for the liquid-level reading ("Lnnn" or "Err ").
// Optional LEAD_ZERO_BLANK_EN blanks leading zeros of the hundreds/tens digits.
module level_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [7:0] level_percent,
  input  logic       level_error,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       display_error,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic LZB_EN = 1'b1;
`else
  localparam logic LZB_EN = 1'b0;
`endif

  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             frame_tick_q, frame_tick_d;
  logic             start_pending_q, start_pending_d;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [19:0]      conv_q, conv_d;
  logic             sample_err_q, sample_err_d;
  logic [11:0]      shadow_bcd_q, shadow_bcd_d;
  logic             shadow_err_q, shadow_err_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             display_error_q, display_error_d;

  logic             frame_wrap;
  logic [19:0]      conv_adj;
  logic [3:0]       hund, tens, units;

  always_comb begin
    refresh_d    = refresh_q + CNT_W'(1);
    digit_idx_d  = digit_idx_q;
    frame_wrap   = 1'b0;
    if (refresh_q == CNT_LAST) begin
      refresh_d   = '0;
      digit_idx_d = digit_idx_q + 2'd1;
      frame_wrap  = (digit_idx_q == 2'd3);
    end
    frame_tick_d = frame_wrap;
  end

  // A frame boundary always re-arms the request, so it wins over a same-cycle consume.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    conv_d          = conv_q;
    sample_err_d    = sample_err_q;
    shadow_bcd_d    = shadow_bcd_q;
    shadow_err_d    = shadow_err_q;
    start_pending_d = start_pending_q;
    conv_adj        = conv_q;

    case (state_q)
      IDLE: begin
        if (start_pending_q) begin
          start_pending_d = 1'b0;
          conv_d          = {12'h000, level_percent};
          sample_err_d    = level_error | (level_percent > 8'd100);
          bit_cnt_d       = 3'd0;
          state_d         = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_q[19:16] >= 4'd5) conv_adj[19:16] = conv_q[19:16] + 4'd3;
        if (conv_q[15:12] >= 4'd5) conv_adj[15:12] = conv_q[15:12] + 4'd3;
        if (conv_q[11:8]  >= 4'd5) conv_adj[11:8]  = conv_q[11:8]  + 4'd3;
        conv_d    = {conv_adj[18:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        shadow_bcd_d = sample_err_q ? 12'h000 : conv_q[19:8];
        shadow_err_d = sample_err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_wrap) start_pending_d = 1'b1;
  end

  assign hund  = shadow_bcd_q[11:8];
  assign tens  = shadow_bcd_q[7:4];
  assign units = shadow_bcd_q[3:0];

  always_comb begin
    an_d            = ~(4'b0001 << digit_idx_q);
    display_error_d = shadow_err_q;
    seg_d           = GLYPH_BLANK;
    case (digit_idx_q)
      2'd0: seg_d = shadow_err_q ? GLYPH_BLANK : digit_glyph(units);
      2'd1: begin
        if (shadow_err_q)                                   seg_d = GLYPH_R;
        else if (LZB_EN && (hund == 4'd0) && (tens == 4'd0)) seg_d = GLYPH_BLANK;
        else                                                seg_d = digit_glyph(tens);
      end
      2'd2: begin
        if (shadow_err_q)                   seg_d = GLYPH_R;
        else if (LZB_EN && (hund == 4'd0))  seg_d = GLYPH_BLANK;
        else                                seg_d = digit_glyph(hund);
      end
      default: seg_d = shadow_err_q ? GLYPH_E : GLYPH_L;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      refresh_q       <= '0;
      digit_idx_q     <= 2'd0;
      frame_tick_q    <= 1'b0;
      start_pending_q <= 1'b1;
      state_q         <= IDLE;
      bit_cnt_q       <= 3'd0;
      conv_q          <= 20'h00000;
      sample_err_q    <= 1'b0;
      shadow_bcd_q    <= 12'h000;
      shadow_err_q    <= 1'b0;
      an_q            <= 4'b1111;
      seg_q           <= GLYPH_BLANK;
      display_error_q <= 1'b0;
    end else begin
      refresh_q       <= refresh_d;
      digit_idx_q     <= digit_idx_d;
      frame_tick_q    <= frame_tick_d;
      start_pending_q <= start_pending_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      conv_q          <= conv_d;
      sample_err_q    <= sample_err_d;
      shadow_bcd_q    <= shadow_bcd_d;
      shadow_err_q    <= shadow_err_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      display_error_q <= display_error_d;
    end
  end

  assign an            = an_q;
  assign seg           = seg_q;
  assign dp            = 1'b1;
  assign display_error = display_error_q;
  assign frame_tick    = frame_tick_q;

endmodule
